// File: rtl/tt_um_adder_seq.sv
// Byte-serial 16-bit add/subtract sequencer: captures A and B LSB first,
// adds in two byte steps, then returns the result LSB first with a ready/valid handshake.
// Optional chained accumulation is enabled with the ADDER_SEQ_ACCUM_EN macro.
//
// state  | meaning
// -------+---------------------------------------------------------
// CAP_A0 | wait for A[7:0] (also samples the add/sub mode)
// CAP_A1 | wait for A[15:8]
// CAP_B0 | wait for B[7:0]
// CAP_B1 | wait for B[15:8]
// ADD_L  | register low result byte and its carry
// ADD_H  | register high result byte and final carry-out
// OUT_L  | present result[7:0] until out_ready
// OUT_H  | present result[15:8] until out_ready
module tt_um_adder_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    CAP_A0 = 3'd0,
    CAP_A1 = 3'd1,
    CAP_B0 = 3'd2,
    CAP_B1 = 3'd3,
    ADD_L  = 3'd4,
    ADD_H  = 3'd5,
    OUT_L  = 3'd6,
    OUT_H  = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic        carry_lo_q, carry_lo_d;
  logic        cout_q, cout_d;
  logic        mode_q, mode_d;

  logic        in_valid;
  logic        out_ready;
  logic        clr;
  logic        sub_in;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic        flag;
  logic [15:0] b_eff;
  logic [8:0]  sum_lo;
  logic [8:0]  sum_hi;
  logic        unused_uio;

  assign in_valid   = uio_in[0];
  assign out_ready  = uio_in[1];
  assign clr        = uio_in[2];
  assign sub_in     = uio_in[3];
  assign unused_uio = &{1'b0, uio_in[7:4]};

  // Subtraction is A + ~B + 1; the +1 rides in as the low-byte carry-in.
  assign b_eff  = mode_q ? ~b_q : b_q;
  assign sum_lo = {1'b0, a_q[7:0]}  + {1'b0, b_eff[7:0]}  + {8'd0, mode_q};
  assign sum_hi = {1'b0, a_q[15:8]} + {1'b0, b_eff[15:8]} + {8'd0, carry_lo_q};

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      CAP_A0, CAP_A1, CAP_B0, CAP_B1: in_ready  = 1'b1;
      ADD_L, ADD_H:                   busy      = 1'b1;
      OUT_L, OUT_H:                   out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    carry_lo_d = carry_lo_q;
    cout_d     = cout_q;
    mode_d     = mode_q;

    if (ena) begin
      if (clr) begin
        state_d    = CAP_A0;
        a_d        = 16'd0;
        b_d        = 16'd0;
        res_d      = 16'd0;
        carry_lo_d = 1'b0;
        cout_d     = 1'b0;
        mode_d     = 1'b0;
      end else begin
        case (state_q)
          CAP_A0: begin
            if (in_valid) begin
              a_d[7:0] = ui_in;
              mode_d   = sub_in;
              state_d  = CAP_A1;
            end
          end
          CAP_A1: begin
            if (in_valid) begin
              a_d[15:8] = ui_in;
              state_d   = CAP_B0;
            end
          end
          CAP_B0: begin
            if (in_valid) begin
              b_d[7:0] = ui_in;
              state_d  = CAP_B1;
            end
          end
          CAP_B1: begin
            if (in_valid) begin
              b_d[15:8] = ui_in;
              state_d   = ADD_L;
            end
          end
          ADD_L: begin
            res_d[7:0] = sum_lo[7:0];
            carry_lo_d = sum_lo[8];
            state_d    = ADD_H;
          end
          ADD_H: begin
            res_d[15:8] = sum_hi[7:0];
            cout_d      = sum_hi[8];
            state_d     = OUT_L;
          end
          OUT_L: begin
            if (out_ready) begin
              state_d = OUT_H;
            end
          end
          OUT_H: begin
            if (out_ready) begin
`ifdef ADDER_SEQ_ACCUM_EN
              // Result becomes the next A; only a new B is collected.
              a_d     = res_q;
              state_d = CAP_B0;
`else
              state_d = CAP_A0;
`endif
            end
          end
          default: state_d = CAP_A0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CAP_A0;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      res_q      <= 16'd0;
      carry_lo_q <= 1'b0;
      cout_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      carry_lo_q <= carry_lo_d;
      cout_q     <= cout_d;
      mode_q     <= mode_d;
    end
  end

  // Flag is carry-out for add, borrow (inverted carry-out) for subtract.
  assign flag = out_valid & (cout_q ^ mode_q);

  always_comb begin
    uo_out = 8'h00;
    if (state_q == OUT_L) begin
      uo_out = res_q[7:0];
    end else if (state_q == OUT_H) begin
      uo_out = res_q[15:8];
    end
  end

  assign uio_out = {busy, flag, out_valid, in_ready, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_adder_seq.sv
// Directed self-checking bench for tt_um_adder_seq; the accumulation scenario
// runs only when ADDER_SEQ_ACCUM_EN is defined.
module tb_tt_um_adder_seq;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic in_valid;
  logic out_ready;
  logic clr;
  logic sub;

  int checks;
  int errors;

  assign uio_in = {4'b0000, sub, clr, out_ready, in_valid};

  tt_um_adder_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: all start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] d, input logic s);
    ui_in    = d;
    sub      = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ui_in    = 8'h00;
  endtask

  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    send_byte(a[7:0], s);
    send_byte(a[15:8], s);
    send_byte(b[7:0], s);
    send_byte(b[15:8], s);
  endtask

  task automatic wait_out(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    while (uio_out[5] !== 1'b1 && cyc < 10) begin
      if (uio_out[7] === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic take_byte();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h10 || uio_oe !== 8'hF0) begin
      errors++;
      $display("FAIL reset_outputs: got uo=%h uio_out=%h oe=%h want 00 10 f0", uo_out, uio_out, uio_oe);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h10 || uio_oe !== 8'hF0) begin
        errors++;
        $display("FAIL reset_idle_%0d: got uo=%h uio_out=%h oe=%h want 00 10 f0", i, uo_out, uio_out, uio_oe);
      end
    end
  endtask

  task automatic test_add();
    int cyc, bc;
    pulse_clear();
    send_op(16'h1234, 16'h00FF, 1'b0);
    wait_out(cyc, bc);
    checks++;
    if (cyc != 2 || bc != 2) begin
      errors++;
      $display("FAIL add_latency: got cycles=%0d busy=%0d want 2 2", cyc, bc);
    end
    checks++;
    if (uo_out !== 8'h33 || uio_out !== 8'h20) begin
      errors++;
      $display("FAIL add_low: got uo=%h uio_out=%h want 33 20", uo_out, uio_out);
    end
    take_byte();
    checks++;
    if (uo_out !== 8'h13 || uio_out !== 8'h20) begin
      errors++;
      $display("FAIL add_high: got uo=%h uio_out=%h want 13 20", uo_out, uio_out);
    end
    take_byte();
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h10) begin
      errors++;
      $display("FAIL add_done: got uo=%h uio_out=%h want 00 10", uo_out, uio_out);
    end
  endtask

  task automatic test_carry();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vs [3];
    logic [7:0]  elo [3];
    logic [7:0]  ehi [3];
    logic        ef [3];
    int cyc, bc;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vs[0] = 1'b0; elo[0] = 8'h00; ehi[0] = 8'h00; ef[0] = 1'b1;
    va[1] = 16'h0000; vb[1] = 16'h0001; vs[1] = 1'b1; elo[1] = 8'hFF; ehi[1] = 8'hFF; ef[1] = 1'b1;
    va[2] = 16'h0100; vb[2] = 16'h0001; vs[2] = 1'b1; elo[2] = 8'hFF; ehi[2] = 8'h00; ef[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_clear();
      send_op(va[i], vb[i], vs[i]);
      wait_out(cyc, bc);
      checks++;
      if (uo_out !== elo[i] || uio_out[6] !== ef[i] || uio_out[5] !== 1'b1) begin
        errors++;
        $display("FAIL carry_low_%0d: got uo=%h flag=%b valid=%b want %h %b 1", i, uo_out, uio_out[6], uio_out[5], elo[i], ef[i]);
      end
      take_byte();
      checks++;
      if (uo_out !== ehi[i] || uio_out[6] !== ef[i]) begin
        errors++;
        $display("FAIL carry_high_%0d: got uo=%h flag=%b want %h %b", i, uo_out, uio_out[6], ehi[i], ef[i]);
      end
      take_byte();
      checks++;
      if (uio_out[6] !== 1'b0) begin
        errors++;
        $display("FAIL carry_flag_idle_%0d: got flag=%b want 0", i, uio_out[6]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc, bc;
    pulse_clear();
    send_op(16'h1234, 16'h00FF, 1'b0);
    wait_out(cyc, bc);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      ui_in    = 8'h77;
      @(negedge clk);
      checks++;
      if (uo_out !== 8'h33 || uio_out !== 8'h20) begin
        errors++;
        $display("FAIL backpressure_%0d: got uo=%h uio_out=%h want 33 20", i, uo_out, uio_out);
      end
    end
    in_valid = 1'b0;
    ui_in    = 8'h00;
    take_byte();
    checks++;
    if (uo_out !== 8'h13) begin
      errors++;
      $display("FAIL backpressure_high: got uo=%h want 13", uo_out);
    end
    // Clear wins over a simultaneous out_ready.
    clr       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h10) begin
      errors++;
      $display("FAIL clear_in_out: got uo=%h uio_out=%h want 00 10", uo_out, uio_out);
    end
  endtask

  task automatic test_abort_freeze();
    int cyc, bc;
    pulse_clear();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    pulse_clear();
    checks++;
    if (uio_out !== 8'h10 || uo_out !== 8'h00) begin
      errors++;
      $display("FAIL abort_clear: got uio_out=%h uo=%h want 10 00", uio_out, uo_out);
    end
    ena      = 1'b0;
    in_valid = 1'b1;
    ui_in    = 8'hAA;
    sub      = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    in_valid = 1'b0;
    ena      = 1'b1;
    send_op(16'h0001, 16'h0002, 1'b0);
    wait_out(cyc, bc);
    checks++;
    if (uo_out !== 8'h03 || uio_out !== 8'h20 || cyc != 2) begin
      errors++;
      $display("FAIL abort_fresh_low: got uo=%h uio_out=%h cycles=%0d want 03 20 2", uo_out, uio_out, cyc);
    end
    // Freeze while presenting: out_ready must not advance.
    ena       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ena       = 1'b1;
    checks++;
    if (uo_out !== 8'h03) begin
      errors++;
      $display("FAIL freeze_out: got uo=%h want 03", uo_out);
    end
    take_byte();
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h20) begin
      errors++;
      $display("FAIL abort_fresh_high: got uo=%h uio_out=%h want 00 20", uo_out, uio_out);
    end
    take_byte();
  endtask

  task automatic test_reset_midop();
    int cyc, bc;
    pulse_clear();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (uio_out !== 8'h10 || uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_midop: got uio_out=%h uo=%h want 10 00", uio_out, uo_out);
    end
    send_byte(8'h44, 1'b0);
    wait_out(cyc, bc);
    checks++;
    if (uio_out[5] !== 1'b0) begin
      errors++;
      $display("FAIL reset_partial: got out_valid=%b want 0", uio_out[5]);
    end
  endtask

`ifdef ADDER_SEQ_ACCUM_EN
  task automatic test_accum();
    int cyc, bc;
    pulse_clear();
    send_op(16'h0001, 16'h0002, 1'b0);
    wait_out(cyc, bc);
    checks++;
    if (uo_out !== 8'h03) begin
      errors++;
      $display("FAIL accum_first: got uo=%h want 03", uo_out);
    end
    take_byte();
    take_byte();
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_out(cyc, bc);
    checks++;
    if (uo_out !== 8'h08 || uio_out[5] !== 1'b1) begin
      errors++;
      $display("FAIL accum_low: got uo=%h valid=%b want 08 1", uo_out, uio_out[5]);
    end
    take_byte();
    checks++;
    if (uo_out !== 8'h00 || uio_out[5] !== 1'b1) begin
      errors++;
      $display("FAIL accum_high: got uo=%h valid=%b want 00 1", uo_out, uio_out[5]);
    end
    take_byte();
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    ui_in     = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    sub       = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_carry();
    test_backpressure();
    test_abort_freeze();
    test_reset_midop();
`ifdef ADDER_SEQ_ACCUM_EN
    test_accum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
